// File: rtl/chain_rx_fifo.sv
// chain_rx_fifo
// Receives the 13-bit data_to_post stream from the last block of the ADC
// daisy chain. Each valid sample is tagged with its position in the current
// conversion frame and buffered in a DEPTH-word FIFO. The SPI/FSM layer drains
// the FIFO one 16-bit word per cycle.
//
// Ports:
//   clk_3p2M        system clock, rising edge
//   rst             asynchronous active-high reset
//   data_from_chain {valid, sample[BITS_ADC-1:0]}
//   adc_ready       SAMP from the chain; its rising edge starts a frame
//   rd_en           read request, one word per cycle
//   clr_flags       single-cycle clear of the sticky flags
//   rd_data         registered read word {ch_tag[3:0], sample[11:0]}
//   rd_valid        high the cycle rd_data is updated
//   empty, full     FIFO status, derived from the registered level
//   level           words stored (0..DEPTH)
//   overflow        sticky: a word was dropped because the FIFO was full
//   frame_err       sticky: short frame or surplus sample seen
//
// The stored word is 4 tag bits plus BITS_ADC sample bits, so the 16-bit
// read word assumes BITS_ADC = 12.
module chain_rx_fifo #(
    parameter int BITS_ADC = 12,
    parameter int N_CH     = 16,
    parameter int DEPTH    = 16,
    parameter int AW       = 4
) (
    input  logic              clk_3p2M,
    input  logic              rst,
    input  logic [BITS_ADC:0] data_from_chain,
    input  logic              adc_ready,
    input  logic              rd_en,
    input  logic              clr_flags,
    output logic [15:0]       rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       level,
    output logic              overflow,
    output logic              frame_err
);

    localparam logic [4:0]  CH_FULL   = 5'(N_CH);
    localparam logic [AW:0] LEVEL_MAX = (AW + 1)'(DEPTH);

    logic                valid;
    logic [BITS_ADC-1:0] sample;
    logic                adc_ready_d;
    logic                seen_frame;
    logic [4:0]          ch_idx;
    logic [4:0]          ch_idx_next;
    logic                fs;
    logic                surplus;
    logic                short_frame;
    logic                wr_req;
    logic                do_wr;
    logic                do_rd;
    logic [3:0]          wr_tag;
    logic [15:0]         wr_word;
    logic [AW:0]         level_next;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [15:0]         mem [DEPTH];

    assign valid  = data_from_chain[BITS_ADC];
    assign sample = data_from_chain[BITS_ADC-1:0];
    assign empty  = (level == {(AW + 1){1'b0}});
    assign full   = (level == LEVEL_MAX);

    // Frame tracking, surplus/short-frame detection and FIFO handshake decode.
    always_comb begin
        fs          = adc_ready & ~adc_ready_d;
        // A sample that lands on the frame edge belongs to the new frame,
        // so it can never be a surplus of the old one.
        surplus     = valid & ~fs & (ch_idx == CH_FULL);
        short_frame = fs & seen_frame & (ch_idx != CH_FULL);
        wr_req      = valid & ~surplus;
        do_rd       = rd_en & ~empty;
        // When full, a same-cycle read frees the slot the write needs.
        do_wr       = wr_req & (~full | do_rd);
        wr_tag      = fs ? 4'd0 : ch_idx[3:0];
        wr_word     = {wr_tag, sample};

        if (fs) begin
            ch_idx_next = valid ? 5'd1 : 5'd0;
        end else if (wr_req && (ch_idx != CH_FULL)) begin
            ch_idx_next = ch_idx + 5'd1;
        end else begin
            ch_idx_next = ch_idx;
        end

        case ({do_wr, do_rd})
            2'b10:   level_next = level + (AW + 1)'(1);
            2'b01:   level_next = level - (AW + 1)'(1);
            default: level_next = level;
        endcase
    end

    // Frame edge detector and per-frame channel counter.
    always_ff @(posedge clk_3p2M or posedge rst) begin
        if (rst) begin
            adc_ready_d <= 1'b0;
            seen_frame  <= 1'b0;
            ch_idx      <= 5'd0;
        end else begin
            adc_ready_d <= adc_ready;
            ch_idx      <= ch_idx_next;
            if (fs) begin
                seen_frame <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk_3p2M) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    // Pointers, occupancy and the registered read port.
    always_ff @(posedge clk_3p2M or posedge rst) begin
        if (rst) begin
            wr_ptr   <= {AW{1'b0}};
            rd_ptr   <= {AW{1'b0}};
            level    <= {(AW + 1){1'b0}};
            rd_data  <= 16'h0000;
            rd_valid <= 1'b0;
        end else begin
            level    <= level_next;
            rd_valid <= do_rd;
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
        end
    end

    // Sticky error flags; a set event in the clear cycle takes priority.
    always_ff @(posedge clk_3p2M or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overflow  <= (wr_req & full & ~do_rd) | (overflow & ~clr_flags);
            frame_err <= surplus | short_frame | (frame_err & ~clr_flags);
        end
    end

endmodule

// File: tb/tb_chain_rx_fifo.sv
// Directed testbench for chain_rx_fifo. Inputs change 1 time unit after each
// rising edge; outputs are sampled at that same point.
module tb_chain_rx_fifo;

    logic        clk_3p2M = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] data_from_chain = 13'd0;
    logic        adc_ready = 1'b0;
    logic        rd_en = 1'b0;
    logic        clr_flags = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        empty;
    logic        full;
    logic [4:0]  level;
    logic        overflow;
    logic        frame_err;

    int compared = 0;
    int mismatched = 0;

    chain_rx_fifo dut (
        .clk_3p2M        (clk_3p2M),
        .rst             (rst),
        .data_from_chain (data_from_chain),
        .adc_ready       (adc_ready),
        .rd_en           (rd_en),
        .clr_flags       (clr_flags),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .empty           (empty),
        .full            (full),
        .level           (level),
        .overflow        (overflow),
        .frame_err       (frame_err)
    );

    always #5 clk_3p2M = ~clk_3p2M;

    task automatic step();
        @(posedge clk_3p2M);
        #1;
    endtask

    // Apply one cycle of inputs, then sample just after the next edge.
    task automatic drive(input logic v, input logic [11:0] s, input logic ar,
                         input logic re, input logic clr);
        data_from_chain = {v, s};
        adc_ready       = ar;
        rd_en           = re;
        clr_flags       = clr;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        compared++;
        if (rd_data !== 16'h0000 || rd_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 ||
            level !== 5'd0 || overflow !== 1'b0 || frame_err !== 1'b0) begin
            mismatched++;
            $display("FAIL reset: rd_data=%h rd_valid=%b empty=%b full=%b level=%0d ovf=%b ferr=%b, need 0000 0 1 0 0 0 0",
                     rd_data, rd_valid, empty, full, level, overflow, frame_err);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fill_drain();
        logic [15:0] exp_word;
        drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) drive(1'b1, 12'(12'h100 + i), 1'b0, 1'b0, 1'b0);
        compared++;
        if (level !== 5'd16 || full !== 1'b1 || empty !== 1'b0 || frame_err !== 1'b0) begin
            mismatched++;
            $display("FAIL fill: level=%0d full=%b empty=%b ferr=%b, need 16 1 0 0", level, full, empty, frame_err);
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
            exp_word = 16'h0100 + 16'(i) + (16'(i) << 12);
            compared++;
            if (rd_valid !== 1'b1 || rd_data !== exp_word) begin
                mismatched++;
                $display("FAIL drain[%0d]: rd_valid=%b rd_data=%h, need 1 %h", i, rd_valid, rd_data, exp_word);
            end
        end
        drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        compared++;
        if (rd_valid !== 1'b0 || empty !== 1'b1 || overflow !== 1'b0 || frame_err !== 1'b0) begin
            mismatched++;
            $display("FAIL drain_end: rd_valid=%b empty=%b ovf=%b ferr=%b, need 0 1 0 0", rd_valid, empty, overflow, frame_err);
        end
    endtask

    task automatic test_surplus();
        drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) drive(1'b1, 12'(12'h200 + i), 1'b0, 1'b0, 1'b0);
        compared++;
        if (frame_err !== 1'b0 || level !== 5'd16) begin
            mismatched++;
            $display("FAIL full_frame: ferr=%b level=%0d, need 0 16", frame_err, level);
        end
        drive(1'b1, 12'hEEE, 1'b0, 1'b0, 1'b0);
        compared++;
        if (level !== 5'd16 || frame_err !== 1'b1 || overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL surplus: level=%0d ferr=%b ovf=%b, need 16 1 0", level, frame_err, overflow);
        end
        drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
        compared++;
        if (frame_err !== 1'b0) begin
            mismatched++;
            $display("FAIL surplus_clr: ferr=%b, need 0", frame_err);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_word;
        // Frame edge and a word together while full: word dropped.
        drive(1'b1, 12'h300, 1'b1, 1'b0, 1'b0);
        compared++;
        if (overflow !== 1'b1 || level !== 5'd16 || frame_err !== 1'b0) begin
            mismatched++;
            $display("FAIL overflow: ovf=%b level=%0d ferr=%b, need 1 16 0", overflow, level, frame_err);
        end
        drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
        compared++;
        if (overflow !== 1'b0 || level !== 5'd16) begin
            mismatched++;
            $display("FAIL ovf_clr: ovf=%b level=%0d, need 0 16", overflow, level);
        end
        // Write while full with a same-cycle read: both complete, no drop.
        drive(1'b1, 12'h301, 1'b0, 1'b1, 1'b0);
        compared++;
        if (overflow !== 1'b0 || level !== 5'd16 || rd_valid !== 1'b1 || rd_data !== 16'h0200) begin
            mismatched++;
            $display("FAIL full_rw: ovf=%b level=%0d rd_valid=%b rd_data=%h, need 0 16 1 0200",
                     overflow, level, rd_valid, rd_data);
        end
        for (int i = 1; i < 17; i++) begin
            drive(1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
            exp_word = (i == 16) ? 16'h1301 : (16'h0200 + 16'(i) + (16'(i) << 12));
            compared++;
            if (rd_valid !== 1'b1 || rd_data !== exp_word) begin
                mismatched++;
                $display("FAIL ovf_drain[%0d]: rd_valid=%b rd_data=%h, need 1 %h", i, rd_valid, rd_data, exp_word);
            end
        end
        drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        compared++;
        if (empty !== 1'b1 || overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL ovf_end: empty=%b ovf=%b, need 1 0", empty, overflow);
        end
    endtask

    task automatic test_short_frame();
        // Previous frame held only 2 words.
        drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        compared++;
        if (frame_err !== 1'b1) begin
            mismatched++;
            $display("FAIL short2: ferr=%b, need 1", frame_err);
        end
        drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) drive(1'b1, 12'(12'h400 + i), 1'b0, 1'b0, 1'b0);
        compared++;
        if (frame_err !== 1'b0 || level !== 5'd12) begin
            mismatched++;
            $display("FAIL frame12: ferr=%b level=%0d, need 0 12", frame_err, level);
        end
        drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        compared++;
        if (frame_err !== 1'b1) begin
            mismatched++;
            $display("FAIL short12: ferr=%b, need 1", frame_err);
        end
        drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
        compared++;
        if (frame_err !== 1'b0) begin
            mismatched++;
            $display("FAIL short_clr: ferr=%b, need 0", frame_err);
        end
        // Empty frame ends on an edge coinciding with clr_flags: set wins.
        drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b1);
        compared++;
        if (frame_err !== 1'b1) begin
            mismatched++;
            $display("FAIL set_wins: ferr=%b, need 1", frame_err);
        end
        drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
        compared++;
        if (frame_err !== 1'b0) begin
            mismatched++;
            $display("FAIL set_wins_clr: ferr=%b, need 0", frame_err);
        end
    endtask

    task automatic test_reset_mid_and_tag();
        for (int i = 0; i < 7; i++) drive(1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
        compared++;
        if (level !== 5'd5 || rd_data !== 16'h6406 || rd_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL pre_rst: level=%0d rd_data=%h rd_valid=%b, need 5 6406 1", level, rd_data, rd_valid);
        end
        rd_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        compared++;
        if (level !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 16'h0000) begin
            mismatched++;
            $display("FAIL async_rst: level=%0d empty=%b rd_valid=%b rd_data=%h, need 0 1 0 0000",
                     level, empty, rd_valid, rd_data);
        end
        step();
        rst = 1'b0;
        // First edge after reset coincides with a valid word: tag 0, no flag.
        drive(1'b1, 12'hABC, 1'b1, 1'b0, 1'b0);
        compared++;
        if (frame_err !== 1'b0 || level !== 5'd1) begin
            mismatched++;
            $display("FAIL first_fs: ferr=%b level=%0d, need 0 1", frame_err, level);
        end
        drive(1'b1, 12'h123, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
        compared++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h0ABC) begin
            mismatched++;
            $display("FAIL tag0: rd_valid=%b rd_data=%h, need 1 0abc", rd_valid, rd_data);
        end
        drive(1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
        compared++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h1123) begin
            mismatched++;
            $display("FAIL tag1: rd_valid=%b rd_data=%h, need 1 1123", rd_valid, rd_data);
        end
    endtask

    task automatic test_empty_read();
        drive(1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
        compared++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h1123 || empty !== 1'b1 ||
            overflow !== 1'b0 || frame_err !== 1'b0) begin
            mismatched++;
            $display("FAIL empty_read: rd_valid=%b rd_data=%h empty=%b ovf=%b ferr=%b, need 0 1123 1 0 0",
                     rd_valid, rd_data, empty, overflow, frame_err);
        end
        drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_surplus();
        test_overflow();
        test_short_frame();
        test_reset_mid_and_tag();
        test_empty_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/chain_rx_fifo.md
Name: chain_rx_fifo

Overview:
- Sits directly downstream of the last BLOCK_DIGITAL in the daisy chain and consumes its 13-bit `data_to_post` stream.
- Tags each valid ADC sample with its position in the current conversion frame and buffers the tagged words in a FIFO.
- The SPI/FSM layer drains the FIFO one 16-bit word at a time.
- Detects dropped or surplus samples per frame and FIFO overflow, and reports both as sticky flags.

Parameters:
- BITS_ADC, 12, ADC sample width; chain word is BITS_ADC+1 bits.
- N_CH, 16, samples expected per frame (4 per block x 4 chained blocks); must be ≤ 16.
- DEPTH, 16, FIFO depth in words; power of two.
- AW, 4, log2(DEPTH).

Ports:
- clk_3p2M, input, 1, system clock; all logic is on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- data_from_chain, input, BITS_ADC+1, chain word; bit BITS_ADC = valid, bits [BITS_ADC-1:0] = sample.
- adc_ready, input, 1, ADC data-ready (SAMP) from the chain; its rising edge marks the frame start.
- rd_en, input, 1, read request, one word per cycle.
- clr_flags, input, 1, single-cycle clear of the sticky flags.
- rd_data, output, 16, registered read word = {ch_tag[3:0], sample[11:0]}.
- rd_valid, output, 1, high the cycle rd_data is updated.
- empty, output, 1, FIFO empty.
- full, output, 1, FIFO full.
- level, output, AW+1, words currently stored (0..DEPTH).
- overflow, output, 1, sticky: a word was dropped because the FIFO was full.
- frame_err, output, 1, sticky: a frame ended with a sample count other than N_CH, or a surplus sample arrived.

Behaviour:
- Reset values: rd_data=0, rd_valid=0, empty=1, full=0, level=0, overflow=0, frame_err=0. Internal state also clears: pointers=0, ch_idx=0, adc_ready_d=0, seen_frame=0.
- Frame edge: `fs = adc_ready & ~adc_ready_d`, where adc_ready_d is a one-cycle registered copy.
- Channel index (ch_idx, 5 bits):
  - On fs, ch_idx <= 0 and seen_frame <= 1.
  - On each accepted valid word, ch_idx <= ch_idx+1.
  - ch_idx saturates at N_CH.
- Tagging: the word is written as {ch_idx[3:0], sample}.
  - If fs and valid occur in the same cycle, the word belongs to the new frame and is tagged 0; ch_idx becomes 1.
- Surplus sample: a valid word arriving with ch_idx==N_CH and no fs that cycle is not written. frame_err is set and ch_idx stays N_CH.
- Short frame: on fs with seen_frame==1 and ch_idx!=N_CH (before the clear), frame_err is set. The first fs after reset never flags.
- FIFO write: occurs when valid is set and the word is not a surplus sample.
  - If full and no read this cycle, the word is dropped and overflow is set.
  - If full and a read happens this cycle, both complete: level unchanged, no overflow.
- FIFO read: when rd_en & ~empty, rd_data <= mem[rd_ptr] and rd_valid=1 on the next cycle (latency 1). rd_ptr then increments.
  - rd_en while empty is ignored: rd_data holds, rd_valid=0, no flag.
- Simultaneous read and write when not full and not empty: level unchanged.
- Simultaneous read and write when empty: the write completes, the read is ignored, and level becomes 1. There is no write-through bypass.
- Pointers: AW-bit, wrapping DEPTH-1 -> 0. empty = (level==0), full = (level==DEPTH), both derived combinationally from registered level.
- Sticky flags: clr_flags clears overflow and frame_err. If a set event occurs in the same cycle as clr_flags, set wins.
- Reset mid-frame or mid-read: all contents are discarded immediately (asynchronous). The next fs is treated as the first frame.

Test Plan:
- Reset, one adc_ready rise, then 16 valid words with samples 0x100..0x10F -> level=16, full=1. Reads return 0x0100, 0x1101, ..., 0xF10F in order; rd_valid is high 1 cycle after each rd_en; empty=1 at the end; no flags.
- Frame of 16 words, then a 17th valid word before the next adc_ready -> 17th is not stored, level=16, frame_err=1, overflow=0.
- Frame of 12 words, then adc_ready rise -> frame_err=1 on the cycle after the edge. Pulse clr_flags -> frame_err=0.
- With DEPTH=16 already full, a new frame's valid word with rd_en=0 -> dropped, overflow=1. Next new-frame word arrives with rd_en=1 while still full -> written, level stays 16, dropped-word count unchanged.
- adc_ready rise coinciding with a valid word 0xABC -> stored as 0x0ABC. The following word is tagged 1.
- rd_en on empty FIFO -> rd_valid=0, rd_data unchanged. Assert rst mid-frame with level=5 -> level=0 and empty=1 immediately. The next frame start does not set frame_err.
